ndma_desc_fetch: RTL and testbench
==================================

NDMA_DESC_FETCH -- requirements
Module: ndma_desc_fetch

Interface
REQ-001 SHALL have parameter CfgBase, default 32'h0, giving the ndma config-port base address.
REQ-002 SHALL have parameter MaxChain, default 256, giving the maximum number of descriptors per chain.
REQ-003 SHALL have parameter TxCntBits, default 8, giving the width of the len field forwarded to ndma.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start-chain pulse
- desc_ptr_i  in  32  first descriptor address
- mem_req_o  out  1  descriptor read request
- mem_gnt_i  in  1  read grant
- mem_addr_o  out  32  read address
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  32  read data
- cfg_req_o  out  1  ndma config-port request
- cfg_we_o  out  1  write enable, always 1
- cfg_gnt_i  in  1  config grant
- cfg_addr_o  out  32  config address
- cfg_wdata_o  out  32  config write data
- cfg_rvalid_i  in  1  config response valid
- tx_done_i  in  1  ndma transfer-done level
- busy_o  out  1  chain in progress
- chain_done_irq_o  out  1  one-cycle pulse at chain end
- err_o  out  1  chain aborted on error; sticky
- desc_count_o  out  16  descriptors completed in the current chain

Function
REQ-005 SHALL implement the descriptor format as four 32-bit words at ptr: +0 src, +4 dst, +8 len, +C next; next==0 terminates the chain.
REQ-006 SHALL implement the FSM states IDLE, FETCH, FETCH_WAIT, CFG, CFG_WAIT, RUN, ERROR.
REQ-007 IDLE SHALL move to FETCH on start_i, loading ptr=desc_ptr_i and clearing desc_count_o and err_o; start_i SHALL be ignored in every other state except ERROR.
REQ-008 On any ptr load, ptr[1:0]!=0 SHALL move the FSM to ERROR with no memory request issued.
REQ-009 FETCH SHALL hold mem_req_o=1 with mem_addr_o=ptr+4*idx until mem_gnt_i; FETCH_WAIT SHALL capture mem_rdata_i on mem_rvalid_i into word idx. The block SHALL keep at most one read outstanding and SHALL take 4 words per descriptor.
REQ-010 CFG SHALL issue four writes in order, each holding cfg_req_o until cfg_gnt_i and then waiting in CFG_WAIT for cfg_rvalid_i before the next:
- CfgBase+0 = src
- CfgBase+4 = dst
- CfgBase+8 = len[TxCntBits-1:0], zero-extended
- CfgBase+C = 32'h1 (start)
REQ-011 RUN SHALL wait for a rising edge of tx_done_i, detected against a registered copy of tx_done_i, then increment desc_count_o.
REQ-012 After RUN completes:
- if next==0, the block SHALL pulse chain_done_irq_o for exactly 1 cycle and return to IDLE;
- otherwise it SHALL load ptr=next and go to FETCH.
REQ-013 A non-zero next SHALL move the FSM to ERROR when desc_count_o==MaxChain after the increment.
REQ-014 busy_o SHALL be 1 in every state except IDLE and ERROR.
REQ-015 In ERROR, err_o SHALL be 1 and busy_o 0; start_i SHALL restart the chain as described for IDLE.
REQ-016 mem_req_o and cfg_req_o SHALL never be asserted in the same cycle.
REQ-017 A mem_gnt_i or cfg_gnt_i arriving in the same cycle as the request SHALL be accepted, giving zero wait.

Reset
REQ-018 While rst_ni is low, the block SHALL drive state IDLE and all outputs, ptr, idx, desc_count_o and the registered tx_done to 0.
REQ-019 Reset asserted mid-chain SHALL abandon the transfer immediately, with no further requests and no irq pulse.

Configuration
REQ-020 When macro NDMA_DESC_ZERO_SKIP_EN is defined, a descriptor with len==0 SHALL issue no cfg writes and no RUN wait; it SHALL count as completed and proceed per REQ-012.
REQ-021 When NDMA_DESC_ZERO_SKIP_EN is undefined, a descriptor with len==0 SHALL move the FSM to ERROR after the fetch, with no cfg writes.

Verification
REQ-022 Single descriptor at 0x100 (src 0x1000, dst 0x2000, len 16, next 0), grants and rvalids immediate, tx_done_i rising 20 cycles after start write -> exactly 4 reads, 4 writes, 1 irq pulse, desc_count_o=1.
REQ-023 Chain of 3 descriptors with random 0-5 cycle gnt/rvalid delays -> 12 reads, 12 writes in order, irq only after the third, desc_count_o=3.
REQ-024 desc_ptr_i=0x102 -> no mem_req_o, err_o=1, busy_o=0; a subsequent start_i with 0x100 -> normal completion.
REQ-025 Self-looping descriptor (next=own address) with MaxChain=4 -> err_o=1 after desc_count_o reaches 4, no irq.
REQ-026 len=0 middle descriptor -> skipped with final desc_count_o=3 under NDMA_DESC_ZERO_SKIP_EN; err_o=1 with desc_count_o=1 without it.
REQ-027 rst_ni low during CFG_WAIT -> all outputs 0 next cycle; start_i after reset -> clean chain.

Source files
------------

// File: rtl/ndma_desc_fetch.sv
// rtl/ndma_desc_fetch.sv - ndma descriptor-chain fetcher: reads 4-word descriptors, programs the ndma config port, waits for tx_done.
// Optional build macro NDMA_DESC_ZERO_SKIP_EN: len==0 descriptors are skipped instead of aborting the chain.
module ndma_desc_fetch #(
    parameter logic [31:0] CfgBase   = 32'h0,
    parameter int          MaxChain  = 256,
    parameter int          TxCntBits = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] desc_ptr_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        cfg_req_o,
    output logic        cfg_we_o,
    input  logic        cfg_gnt_i,
    output logic [31:0] cfg_addr_o,
    output logic [31:0] cfg_wdata_o,
    input  logic        cfg_rvalid_i,
    input  logic        tx_done_i,
    output logic        busy_o,
    output logic        chain_done_irq_o,
    output logic        err_o,
    output logic [15:0] desc_count_o
);

    typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, CFG, CFG_WAIT, RUN, ERROR} state_e;

    localparam logic [31:0] LenMask = (TxCntBits >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << TxCntBits) - 32'd1);

    state_e      state;
    logic [31:0] ptr;
    logic [1:0]  idx;
    logic [31:0] words [4];
    logic        tx_done_q;

    logic        tx_rise;
    logic        last_word;
    logic        len_zero;
    logic        complete;
    logic [31:0] next_ptr;
    logic [15:0] count_inc;
    logic [31:0] cfg_w [4];

    assign tx_rise   = tx_done_i & ~tx_done_q;
    assign last_word = (state == FETCH_WAIT) && mem_rvalid_i && (idx == 2'd3);
    assign len_zero  = (words[2] == 32'd0);
    assign count_inc = desc_count_o + 16'd1;
    // A skipped descriptor completes while its next word is still on the read bus.
    assign next_ptr  = (state == RUN) ? words[3] : mem_rdata_i;

`ifdef NDMA_DESC_ZERO_SKIP_EN
    assign complete = ((state == RUN) && tx_rise) || (last_word && len_zero);
`else
    assign complete = (state == RUN) && tx_rise;
`endif

    always_comb begin
        cfg_w[0] = words[0];
        cfg_w[1] = words[1];
        cfg_w[2] = words[2] & LenMask;
        cfg_w[3] = 32'h1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            ptr              <= 32'd0;
            idx              <= 2'd0;
            tx_done_q        <= 1'b0;
            mem_req_o        <= 1'b0;
            mem_addr_o       <= 32'd0;
            cfg_req_o        <= 1'b0;
            cfg_we_o         <= 1'b0;
            cfg_addr_o       <= 32'd0;
            cfg_wdata_o      <= 32'd0;
            busy_o           <= 1'b0;
            chain_done_irq_o <= 1'b0;
            err_o            <= 1'b0;
            desc_count_o     <= 16'd0;
            for (int i = 0; i < 4; i++) words[i] <= 32'd0;
        end else begin
            tx_done_q        <= tx_done_i;
            cfg_we_o         <= 1'b1;
            chain_done_irq_o <= 1'b0;
            if (complete) begin
                desc_count_o <= count_inc;
                if (next_ptr == 32'd0) begin
                    chain_done_irq_o <= 1'b1;
                    busy_o           <= 1'b0;
                    state            <= IDLE;
                end else if (count_inc == 16'(MaxChain) || next_ptr[1:0] != 2'b00) begin
                    err_o  <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ERROR;
                end else begin
                    ptr        <= next_ptr;
                    idx        <= 2'd0;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= next_ptr;
                    state      <= FETCH;
                end
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (start_i) begin
                            desc_count_o <= 16'd0;
                            idx          <= 2'd0;
                            ptr          <= desc_ptr_i;
                            if (desc_ptr_i[1:0] != 2'b00) begin
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                                state  <= ERROR;
                            end else begin
                                err_o      <= 1'b0;
                                busy_o     <= 1'b1;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= desc_ptr_i;
                                state      <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_gnt_i) begin
                            mem_req_o <= 1'b0;
                            state     <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (mem_rvalid_i) begin
                            words[idx] <= mem_rdata_i;
                            if (idx != 2'd3) begin
                                idx        <= idx + 2'd1;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= ptr + {28'd0, idx + 2'd1, 2'b00};
                                state      <= FETCH;
                            end else if (len_zero) begin
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                                state  <= ERROR;
                            end else begin
                                idx         <= 2'd0;
                                cfg_req_o   <= 1'b1;
                                cfg_addr_o  <= CfgBase;
                                cfg_wdata_o <= cfg_w[0];
                                state       <= CFG;
                            end
                        end
                    end
                    CFG: begin
                        if (cfg_gnt_i) begin
                            cfg_req_o <= 1'b0;
                            state     <= CFG_WAIT;
                        end
                    end
                    CFG_WAIT: begin
                        if (cfg_rvalid_i) begin
                            if (idx == 2'd3) begin
                                state <= RUN;
                            end else begin
                                idx         <= idx + 2'd1;
                                cfg_req_o   <= 1'b1;
                                cfg_addr_o  <= CfgBase + {28'd0, idx + 2'd1, 2'b00};
                                cfg_wdata_o <= cfg_w[idx + 2'd1];
                                state       <= CFG;
                            end
                        end
                    end
                    RUN: begin
                    end
                    default: begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ndma_desc_fetch.sv
// tb/tb_ndma_desc_fetch.sv - directed self-checking bench for ndma_desc_fetch with memory and config-port responders.
module tb_ndma_desc_fetch;

    localparam logic [31:0] CFG_BASE = 32'h4000_0000;
    localparam int          TX_DLY   = 20;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] desc_ptr_i = 32'd0;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        cfg_req_o;
    logic        cfg_we_o;
    logic        cfg_gnt_i = 1'b0;
    logic [31:0] cfg_addr_o;
    logic [31:0] cfg_wdata_o;
    logic        cfg_rvalid_i = 1'b0;
    logic        tx_done_i = 1'b0;
    logic        busy_o;
    logic        chain_done_irq_o;
    logic        err_o;
    logic [15:0] desc_count_o;

    ndma_desc_fetch #(
        .CfgBase  (CFG_BASE),
        .MaxChain (4),
        .TxCntBits(8)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .desc_ptr_i      (desc_ptr_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .cfg_req_o       (cfg_req_o),
        .cfg_we_o        (cfg_we_o),
        .cfg_gnt_i       (cfg_gnt_i),
        .cfg_addr_o      (cfg_addr_o),
        .cfg_wdata_o     (cfg_wdata_o),
        .cfg_rvalid_i    (cfg_rvalid_i),
        .tx_done_i       (tx_done_i),
        .busy_o          (busy_o),
        .chain_done_irq_o(chain_done_irq_o),
        .err_o           (err_o),
        .desc_count_o    (desc_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int dly_max = 0;

    logic [31:0] mem [256];
    logic [31:0] rd_log[$], wa_log[$], wd_log[$];
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
    int   irq_cnt = 0;
    logic [15:0] irq_at_count = 16'd0;
    logic irq_prev = 1'b0, irq_wide = 1'b0, overlap = 1'b0, we_bad = 1'b0, mem_req_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int pick_dly();
        return (dly_max == 0) ? 0 : int'($urandom_range(dly_max, 0));
    endfunction

    // Memory read responder: one grant per request, rvalid a random number of cycles later.
    initial begin : mem_resp
        int m_wait, m_rwait;
        logic [31:0] m_addr;
        m_wait = -1; m_rwait = -1; m_addr = 32'd0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (!rst_ni) begin
                m_wait = -1; m_rwait = -1;
            end else if (m_rwait >= 0) begin
                if (m_rwait == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem[m_addr[9:2]];
                end
                m_rwait--;
            end else if (mem_req_o) begin
                if (m_wait < 0) m_wait = pick_dly();
                if (m_wait == 0) begin
                    mem_gnt_i = 1'b1;
                    m_addr = mem_addr_o;
                    rd_log.push_back(mem_addr_o);
                    m_rwait = pick_dly();
                    m_wait = -1;
                end else m_wait--;
            end
        end
    end

    // Config-port responder plus the ndma model raising tx_done after the start write.
    initial begin : cfg_resp
        int c_wait, c_rwait, tx_cnt, tx_hold;
        c_wait = -1; c_rwait = -1; tx_cnt = 0; tx_hold = 0;
        forever begin
            @(negedge clk_i);
            cfg_gnt_i = 1'b0; cfg_rvalid_i = 1'b0;
            if (!rst_ni) begin
                c_wait = -1; c_rwait = -1; tx_cnt = 0; tx_hold = 0; tx_done_i = 1'b0;
            end else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_done_i = 1'b1; tx_hold = 3; end
                end else if (tx_hold > 0) begin
                    tx_hold--;
                    if (tx_hold == 0) tx_done_i = 1'b0;
                end
                if (c_rwait >= 0) begin
                    if (c_rwait == 0) cfg_rvalid_i = 1'b1;
                    c_rwait--;
                end else if (cfg_req_o) begin
                    if (c_wait < 0) c_wait = pick_dly();
                    if (c_wait == 0) begin
                        cfg_gnt_i = 1'b1;
                        wa_log.push_back(cfg_addr_o);
                        wd_log.push_back(cfg_wdata_o);
                        if (cfg_addr_o == CFG_BASE + 32'hC) tx_cnt = TX_DLY;
                        c_rwait = pick_dly();
                        c_wait = -1;
                    end else c_wait--;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (mem_req_o && cfg_req_o) overlap = 1'b1;
            if (cfg_req_o && !cfg_we_o) we_bad = 1'b1;
            if (mem_req_o) mem_req_seen = 1'b1;
            if (chain_done_irq_o) begin irq_cnt++; irq_at_count = desc_count_o; end
            if (chain_done_irq_o && irq_prev) irq_wide = 1'b1;
            irq_prev = chain_done_irq_o;
        end
    end

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        irq_cnt = 0; mem_req_seen = 1'b0;
    endtask

    // mode 0: memory only, 1: expect the 4 reads, 2: expect reads and the 4 cfg writes
    task automatic put_desc(input logic [31:0] a, s, d, l, n, input int mode);
        mem[a[9:2]] = s; mem[a[9:2] + 8'd1] = d; mem[a[9:2] + 8'd2] = l; mem[a[9:2] + 8'd3] = n;
        if (mode >= 1) for (int i = 0; i < 4; i++) exp_rd.push_back(a + 32'(4 * i));
        if (mode == 2) begin
            exp_wa.push_back(CFG_BASE);         exp_wd.push_back(s);
            exp_wa.push_back(CFG_BASE + 32'h4); exp_wd.push_back(d);
            exp_wa.push_back(CFG_BASE + 32'h8); exp_wd.push_back(l & 32'hFF);
            exp_wa.push_back(CFG_BASE + 32'hC); exp_wd.push_back(32'h1);
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nrd"}, 32'(rd_log.size()), 32'(exp_rd.size()));
        check({tag, "_nwr"}, 32'(wa_log.size()), 32'(exp_wa.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
        for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++) begin
            check($sformatf("%s_wa%0d", tag, i), wa_log[i], exp_wa[i]);
            check($sformatf("%s_wd%0d", tag, i), wd_log[i], exp_wd[i]);
        end
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_we"}, 32'(we_bad), 32'd0);
        check({tag, "_irqw"}, 32'(irq_wide), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, mem_req_o, cfg_req_o, cfg_we_o, busy_o, chain_done_irq_o, err_o}, 32'd0);
        check({tag, "_bus"}, mem_addr_o | cfg_addr_o | cfg_wdata_o, 32'd0);
        check({tag, "_cnt"}, 32'(desc_count_o), 32'd0);
    endtask

    task automatic run_chain(input logic [31:0] p);
        @(negedge clk_i); desc_ptr_i = p; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        for (int c = 0; c < 3000 && busy_o; c++) @(negedge clk_i);
        check("timeout", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin : main
        bit got_gnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        #2 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single descriptor, zero-wait handshakes
        clear_logs(); dly_max = 0;
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16, 32'h0, 2);
        run_chain(32'h100);
        compare_logs("single");
        check("single_irq", 32'(irq_cnt), 32'd1);
        check("single_cnt", 32'(desc_count_o), 32'd1);
        check("single_err", 32'(err_o), 32'd0);

        // three-descriptor chain with random handshake delays; len 0x1FF exercises truncation
        clear_logs(); dly_max = 5;
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16,   32'h140, 2);
        put_desc(32'h140, 32'h1100, 32'h2100, 32'h1FF,  32'h180, 2);
        put_desc(32'h180, 32'h1200, 32'h2200, 32'd4,    32'h0,   2);
        run_chain(32'h100);
        compare_logs("chain3");
        check("chain3_irq", 32'(irq_cnt), 32'd1);
        check("chain3_irq_at", 32'(irq_at_count), 32'd3);
        check("chain3_cnt", 32'(desc_count_o), 32'd3);

        // misaligned pointer, then recovery from ERROR
        clear_logs(); dly_max = 0;
        run_chain(32'h102);
        check("misal_req", 32'(mem_req_seen), 32'd0);
        check("misal_err", 32'(err_o), 32'd1);
        check("misal_busy", 32'(busy_o), 32'd0);
        check("misal_nrd", 32'(rd_log.size()), 32'd0);
        clear_logs();
        put_desc(32'h100, 32'h3000, 32'h4000, 32'd8, 32'h0, 2);
        run_chain(32'h100);
        compare_logs("recover");
        check("recover_err", 32'(err_o), 32'd0);
        check("recover_irq", 32'(irq_cnt), 32'd1);
        check("recover_cnt", 32'(desc_count_o), 32'd1);

        // self-looping descriptor hits MaxChain = 4
        clear_logs(); dly_max = 1;
        for (int i = 0; i < 4; i++) put_desc(32'h200, 32'h5000, 32'h6000, 32'd32, 32'h200, 2);
        run_chain(32'h200);
        compare_logs("loop");
        check("loop_err", 32'(err_o), 32'd1);
        check("loop_cnt", 32'(desc_count_o), 32'd4);
        check("loop_irq", 32'(irq_cnt), 32'd0);

        // zero-length middle descriptor
        clear_logs(); dly_max = 2;
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16, 32'h140, 2);
        put_desc(32'h140, 32'h1100, 32'h2100, 32'd0,  32'h180, 1);
`ifdef NDMA_DESC_ZERO_SKIP_EN
        put_desc(32'h180, 32'h1200, 32'h2200, 32'd4,  32'h0,   2);
        run_chain(32'h100);
        compare_logs("zlen");
        check("zlen_err", 32'(err_o), 32'd0);
        check("zlen_cnt", 32'(desc_count_o), 32'd3);
        check("zlen_irq", 32'(irq_cnt), 32'd1);
`else
        put_desc(32'h180, 32'h1200, 32'h2200, 32'd4,  32'h0,   0);
        run_chain(32'h100);
        compare_logs("zlen");
        check("zlen_err", 32'(err_o), 32'd1);
        check("zlen_cnt", 32'(desc_count_o), 32'd1);
        check("zlen_irq", 32'(irq_cnt), 32'd0);
`endif

        // reset while waiting for a config response
        clear_logs(); dly_max = 0;
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16, 32'h0, 0);
        @(negedge clk_i); desc_ptr_i = 32'h100; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        got_gnt = 1'b0;
        for (int c = 0; c < 200 && !got_gnt; c++) begin
            @(negedge clk_i); #1;
            got_gnt = cfg_gnt_i;
        end
        check("rstmid_gnt", 32'(got_gnt), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i); #1;
        check_outputs_zero("rstmid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_req_seen = 1'b0;
        repeat (10) @(negedge clk_i);
        check("rstmid_idle_req", 32'(mem_req_seen), 32'd0);
        check("rstmid_irq", 32'(irq_cnt), 32'd0);
        clear_logs();
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16, 32'h0, 2);
        run_chain(32'h100);
        compare_logs("after_rst");
        check("after_rst_irq", 32'(irq_cnt), 32'd1);
        check("after_rst_cnt", 32'(desc_count_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
